// File: rtl/alu_sequencer_pkg.sv
// Shared ALU sequencer definitions: opcodes, latency classes,
// FSM state encoding and result error codes.
package alu_defs;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_SHL  = 5'b00001;
  localparam logic [4:0] OP_SHR  = 5'b00010;
  localparam logic [4:0] OP_SHRA = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b00100;
  localparam logic [4:0] OP_ROR  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_ADD  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_ILL = 2'b01;
  localparam logic [1:0] ERR_DZ  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LAT_NONE = 2'd0,
    LAT_ALU  = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_cls_t;

  function automatic lat_cls_t op_class(
    input logic [4:0] op
  );
    lat_cls_t c;
    c = LAT_NONE;
    unique case (1'b1)
      (op >= OP_SHL && op <= OP_SUB): c = LAT_ALU;
      (op == OP_MUL):                 c = LAT_MUL;
      (op == OP_DIV):                 c = LAT_DIV;
      default:                        c = LAT_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer_op_decode.sv
// Opcode decoder: op -> {legal, latency in cycles}.
// Ports: op in; legal, lat out (lat is 0 for illegal ops).
module alu_op_decode
  import alu_defs::*;
#(
  parameter int CNT_W   = 7,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 32,
  parameter int DIV_LAT = 33
) (
  input  logic [4:0]       op,
  output logic             legal,
  output logic [CNT_W-1:0] lat
);

  lat_cls_t cls;

  assign cls = op_class(op);

  always_comb begin
    legal = 1'b1;
    lat   = '0;
    unique case (cls)
      LAT_ALU: lat = CNT_W'(ALU_LAT);
      LAT_MUL: lat = CNT_W'(MUL_LAT);
      LAT_DIV: lat = CNT_W'(DIV_LAT);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one ALU op at a time: req handshake in, ALU drive out,
// result captured after a per-op latency and held on res handshake.
// Ports: clk/clear; req_*; alu_a/b/op out, alu_z in; res_*; busy.
module alu_sequencer
  import alu_defs::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 32,
  parameter int DIV_LAT = 33
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [4:0]          alu_op,
  input  logic [2*DATA_W-1:0] alu_z,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_hi,
  output logic [DATA_W-1:0]   res_lo,
  output logic [1:0]          res_err,
  output logic                busy
);

  localparam int MAX_MD  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MAX_LAT = (ALU_LAT > MAX_MD) ? ALU_LAT : MAX_MD;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic [CNT_W-1:0] dec_lat;
  logic             div0;

  alu_op_decode #(
    .CNT_W   (CNT_W),
    .ALU_LAT (ALU_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_dec (
    .op    (req_op),
    .legal (legal),
    .lat   (dec_lat)
  );

  assign div0      = (req_op == OP_DIV) && (req_b == '0);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_NOP;
      res_valid <= 1'b0;
      res_hi    <= '0;
      res_lo    <= '0;
      res_err   <= ERR_OK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            // Error results bypass the ALU entirely.
            if (!legal) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_err   <= ERR_ILL;
              res_hi    <= '0;
              res_lo    <= '0;
            end else if (div0) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_err   <= ERR_DZ;
              res_hi    <= '0;
              res_lo    <= '0;
            end else begin
              state  <= S_EXEC;
              alu_a  <= req_a;
              alu_b  <= req_b;
              alu_op <= req_op;
              cnt    <= dec_lat;
            end
          end
        end
        S_EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_hi    <= alu_z[2*DATA_W-1:DATA_W];
            res_lo    <= alu_z[DATA_W-1:0];
            res_err   <= ERR_OK;
            alu_op    <= OP_NOP;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          res_valid <= 1'b0;
          alu_op    <= OP_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a
// behavioural signed ALU model driving alu_z.
module tb_alu_sequencer;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [63:0] alu_z;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [1:0]  res_err;
  logic        busy;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  err;
    int          lat;
    logic [4:0]  op;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer dut (
    .clk       (clk),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_z     (alu_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_err   (res_err),
    .busy      (busy)
  );

  // Garbage on NOP so a stray capture is visible.
  always_comb begin
    alu_z = 64'hA5A5_A5A5_5A5A_5A5A;
    case (alu_op)
      OP_AND: alu_z = {32'd0, alu_a & alu_b};
      OP_ADD: alu_z = {32'd0, alu_a + alu_b};
      OP_SUB: alu_z = {32'd0, alu_a - alu_b};
      OP_MUL: alu_z = $signed(64'($signed(alu_a)))
                    * $signed(64'($signed(alu_b)));
      OP_DIV: if (alu_b != 0)
                alu_z = {alu_a % alu_b, alu_a / alu_b};
      default: ;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] op,
                      input logic [31:0] hi,
                      input logic [31:0] lo,
                      input logic [1:0] err,
                      input int lat);
    exp_t e;
    e.op  = op;
    e.hi  = hi;
    e.lo  = lo;
    e.err = err;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at the negedge right after the accept edge.
  task automatic after_accept(input logic [4:0] op,
                              input logic [1:0] err);
    req_valid = 1'b0;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0BAD_F00D;
    acc_cyc   = cyc;
    chk("alu_op_start", 64'(alu_op),
        (err == ERR_OK) ? 64'(op) : 64'(OP_NOP));
  endtask

  task automatic send(input logic [4:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] hi,
                      input logic [31:0] lo,
                      input logic [1:0] err,
                      input int lat);
    int n;
    @(negedge clk);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 200), 64'(1));
    push(op, hi, lo, err, lat);
    @(posedge clk);
    @(negedge clk);
    after_accept(op, err);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = 0;
    while (!res_valid && n < 100) begin
      chk("exec_busy", {62'd0, busy, req_ready}, 64'b10);
      chk("exec_op", 64'(alu_op), 64'(e.op));
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
    chk("res_hi", 64'(res_hi), 64'(e.hi));
    chk("res_lo", 64'(res_lo), 64'(e.lo));
    chk("res_err", 64'(res_err), 64'(e.err));
    chk("done_op", 64'(alu_op), 64'(OP_NOP));
    chk("done_busy", {62'd0, busy, req_ready}, 64'b10);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_data", {res_hi, res_lo}, {e.hi, e.lo});
      chk("hold_ready", 64'(req_ready), 64'(0));
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("pop_valid", 64'(res_valid), 64'(0));
    chk("pop_idle", {62'd0, busy, req_ready}, 64'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    exp_t drop;
    clear     = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_op", 64'(alu_op), 64'(OP_NOP));
    chk("rst_ab", {alu_a, alu_b}, 64'd0);
    chk("rst_res", {res_hi, res_lo}, 64'd0);
    chk("rst_err", 64'(res_err), 64'(ERR_OK));

    // Single-cycle ops.
    send(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd12, ERR_OK, 1);
    collect(0);
    send(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF,
         32'd0, 32'h00F0_1234, ERR_OK, 1);
    collect(1);

    // Signed multiply, full latency.
    send(OP_MUL, 32'hFFFF_FFFF, 32'd2,
         32'hFFFF_FFFF, 32'hFFFF_FFFE, ERR_OK, 32);
    collect(0);

    // Divide with stalled consumer and a waiting request;
    // that request must be taken the edge after the pop.
    send(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, ERR_OK, 33);
    req_op    = OP_ADD;
    req_a     = 32'd3;
    req_b     = 32'd4;
    req_valid = 1'b1;
    push(OP_ADD, 32'd0, 32'd7, ERR_OK, 1);
    collect(5);
    chk("b2b_held", 64'(req_valid), 64'(1));
    @(posedge clk);
    @(negedge clk);
    after_accept(OP_ADD, ERR_OK);
    collect(0);

    // Error paths never drive the ALU.
    send(OP_DIV, 32'd10, 32'd0, 32'd0, 32'd0, ERR_DZ, 0);
    collect(0);
    send(5'b10000, 32'd1, 32'd2, 32'd0, 32'd0, ERR_ILL, 0);
    collect(0);
    send(OP_NOP, 32'd1, 32'd2, 32'd0, 32'd0, ERR_ILL, 0);
    collect(0);

    // Abort a multiply mid-flight.
    send(OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, ERR_OK, 32);
    repeat (9) @(negedge clk);
    chk("pre_clear_busy", 64'(busy), 64'(1));
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    drop = sb.pop_front();
    chk("clr_ready", 64'(req_ready), 64'(1));
    chk("clr_valid", 64'(res_valid), 64'(0));
    chk("clr_busy", 64'(busy), 64'(0));
    chk("clr_op", 64'(alu_op), 64'(OP_NOP));
    chk("clr_res", {res_hi, res_lo}, 64'd0);
    chk("clr_dropped_op", 64'(drop.op), 64'(OP_MUL));
    repeat (40) @(negedge clk);
    chk("clr_no_late", 64'(res_valid), 64'(0));
    send(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd2, ERR_OK, 1);
    collect(0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
